// File: rtl/sensor_pkg.sv
// Shared definitions for the S15611 line-packet format, used by both the
// acquisition-side packer and the receive-side parser.
//   - parser FSM state encoding (legacy 3-bit constants, also exported on dbg_state)
//   - default header/footer framing words and default line length
//   - pixel_pair_t: the two 12-bit pixels carried by one data word
//   - pads_clear(): true when the unused nibbles of a data word are zero
package sensor_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TSTAMP  = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_FOOTER  = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    localparam logic [31:0] SENSOR_HEADER = 32'hAAAA_AAAA;
    localparam logic [31:0] SENSOR_FOOTER = 32'h5555_5555;
    localparam int          SENSOR_PIXELS = 1024;

    // hi = even pixel (word bits [27:16]), lo = odd pixel (word bits [11:0])
    typedef struct packed {
        logic [11:0] hi;
        logic [11:0] lo;
    } pixel_pair_t;

    function automatic logic pads_clear(input logic [31:0] word);
        return (word[31:28] == 4'h0) && (word[15:12] == 4'h0);
    endfunction

endpackage

// File: rtl/sensor_packet_parser_pixel_unpacker.sv
// pixel_unpacker: serialises one accepted data word into two pixel beats.
// The even pixel is registered on the load edge, the odd pixel one cycle
// later; lo_pending is high in between and is used upstream to stall the
// stream so a new word can never overlap a pending odd pixel.
// Ports:
//   master_clock, resetn  clock, synchronous active-low reset
//   load                  accepted data word whose pixels are to be emitted
//   pair                  the word's two pixels
//   base_index            pixel index of the even pixel (2k)
//   lo_pending            odd pixel still to be emitted next cycle
//   pixel_data/index/valid  registered pixel output
module pixel_unpacker
    import sensor_pkg::*;
(
    input  logic        master_clock,
    input  logic        resetn,
    input  logic        load,
    input  pixel_pair_t pair,
    input  logic [9:0]  base_index,
    output logic        lo_pending,
    output logic [11:0] pixel_data,
    output logic [9:0]  pixel_index,
    output logic        pixel_valid
);

    logic        lo_pending_q, lo_pending_d;
    logic [11:0] lo_pix_q, lo_pix_d;
    logic [11:0] pix_data_q, pix_data_d;
    logic [9:0]  pix_idx_q, pix_idx_d;
    logic        pix_valid_q, pix_valid_d;

    always_comb begin
        lo_pending_d = 1'b0;
        lo_pix_d     = lo_pix_q;
        pix_data_d   = pix_data_q;
        pix_idx_d    = pix_idx_q;
        pix_valid_d  = 1'b0;
        if (load) begin
            pix_data_d   = pair.hi;
            pix_idx_d    = base_index;
            pix_valid_d  = 1'b1;
            lo_pix_d     = pair.lo;
            lo_pending_d = 1'b1;
        end else if (lo_pending_q) begin
            pix_data_d  = lo_pix_q;
            pix_idx_d   = pix_idx_q + 10'd1;
            pix_valid_d = 1'b1;
        end
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            lo_pending_q <= 1'b0;
            lo_pix_q     <= '0;
            pix_data_q   <= '0;
            pix_idx_q    <= '0;
            pix_valid_q  <= 1'b0;
        end else begin
            lo_pending_q <= lo_pending_d;
            lo_pix_q     <= lo_pix_d;
            pix_data_q   <= pix_data_d;
            pix_idx_q    <= pix_idx_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

    assign lo_pending  = lo_pending_q;
    assign pixel_data  = pix_data_q;
    assign pixel_index = pix_idx_q;
    assign pixel_valid = pix_valid_q;

endmodule

// File: rtl/sensor_packet_parser.sv
// sensor_packet_parser: AXI4-Stream receive parser for S15611 line packets
// (header, timestamp, PIXELS/2 packed pixel words, footer). Validates
// framing, recovers line timestamp and inter-line period, unpacks pixels,
// counts good and malformed packets and resynchronises on the next header.
// Ports:
//   master_clock, resetn            clock, synchronous active-low reset
//   data_tdata/tvalid/tlast/tready  input stream
//   pixel_data/index/valid          unpacked pixel beats
//   line_timestamp, line_period     current line timestamp, delta to previous good line
//   line_done, line_error           one-cycle pulses per good / malformed packet
//   line_count, error_count         good packets (wraps), bad packets (saturates)
//   dbg_state                       current FSM state
// Build option: PARSER_PAD_CHECK_EN rejects data words with nonzero pad nibbles.
//
// state    | meaning
// IDLE     | hunting for a header word, everything else dropped
// TSTAMP   | next beat is the line timestamp
// DATA     | receiving packed pixel words
// FOOTER   | next beat must be the footer with tlast
// DISCARD  | dropping beats of a malformed packet until tlast
module sensor_packet_parser
    import sensor_pkg::*;
#(
    parameter int          PIXELS       = SENSOR_PIXELS,
    parameter logic [31:0] HEADER_VALUE = SENSOR_HEADER,
    parameter logic [31:0] FOOTER_VALUE = SENSOR_FOOTER
) (
    input  logic        master_clock,
    input  logic        resetn,
    input  logic [31:0] data_tdata,
    input  logic        data_tvalid,
    input  logic        data_tlast,
    output logic        data_tready,
    output logic [11:0] pixel_data,
    output logic [9:0]  pixel_index,
    output logic        pixel_valid,
    output logic [31:0] line_timestamp,
    output logic [31:0] line_period,
    output logic        line_done,
    output logic        line_error,
    output logic [15:0] line_count,
    output logic [15:0] error_count,
    output logic [2:0]  dbg_state
);

    localparam int WCNT_W = (PIXELS / 2 > 1) ? $clog2(PIXELS / 2) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PIXELS / 2 - 1);

    logic [2:0]        state_q, state_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]       ts_q, ts_d;
    logic [31:0]       prev_ts_q, prev_ts_d;
    logic              have_prev_q, have_prev_d;
    logic [31:0]       period_q, period_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       line_cnt_q, line_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    logic              lo_pending;
    logic              accept;
    logic              pad_bad;
    logic              word_load;
    pixel_pair_t       word_pair;

    assign data_tready = resetn && !lo_pending;
    assign accept      = data_tvalid && data_tready;
    assign word_pair   = '{hi: data_tdata[27:16], lo: data_tdata[11:0]};

`ifdef PARSER_PAD_CHECK_EN
    assign pad_bad = !pads_clear(data_tdata);
`else
    logic unused_pad_bits;
    assign unused_pad_bits = ^{data_tdata[31:28], data_tdata[15:12]};
    assign pad_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        ts_d        = ts_q;
        prev_ts_d   = prev_ts_q;
        have_prev_d = have_prev_q;
        period_d    = period_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        line_cnt_d  = line_cnt_q;
        err_cnt_d   = err_cnt_q;
        word_load   = 1'b0;
        // flagged packets: a tlast beat already ends the packet, otherwise drain it
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_tdata == HEADER_VALUE && !data_tlast) begin
                        state_d    = ST_TSTAMP;
                        word_cnt_d = '0;
                    end
                end
                ST_TSTAMP: begin
                    ts_d = data_tdata;
                    if (data_tlast) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    word_load = !pad_bad;
                    if (pad_bad || data_tlast) begin
                        err_d   = 1'b1;
                        state_d = data_tlast ? ST_IDLE : ST_DISCARD;
                    end else if (word_cnt_q == LAST_WORD) begin
                        state_d = ST_FOOTER;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
                ST_FOOTER: begin
                    if (data_tdata == FOOTER_VALUE && data_tlast) begin
                        done_d      = 1'b1;
                        line_cnt_d  = line_cnt_q + 16'd1;
                        period_d    = have_prev_q ? (ts_q - prev_ts_q) : 32'd0;
                        prev_ts_d   = ts_q;
                        have_prev_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = data_tlast ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (data_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (err_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            ts_q        <= '0;
            prev_ts_q   <= '0;
            have_prev_q <= 1'b0;
            period_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            line_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            ts_q        <= ts_d;
            prev_ts_q   <= prev_ts_d;
            have_prev_q <= have_prev_d;
            period_q    <= period_d;
            done_q      <= done_d;
            err_q       <= err_d;
            line_cnt_q  <= line_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    pixel_unpacker u_unpacker (
        .master_clock (master_clock),
        .resetn       (resetn),
        .load         (word_load),
        .pair         (word_pair),
        .base_index   (10'({word_cnt_q, 1'b0})),
        .lo_pending   (lo_pending),
        .pixel_data   (pixel_data),
        .pixel_index  (pixel_index),
        .pixel_valid  (pixel_valid)
    );

    assign line_timestamp = ts_q;
    assign line_period    = period_q;
    assign line_done      = done_q;
    assign line_error     = err_q;
    assign line_count     = line_cnt_q;
    assign error_count    = err_cnt_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_sensor_packet_parser.sv
module tb_sensor_packet_parser;

    localparam int          NPIX   = 1024;
    localparam int          NWORDS = NPIX / 2;
    localparam logic [31:0] HDR    = 32'hAAAA_AAAA;
    localparam logic [31:0] FTR    = 32'h5555_5555;

    logic        master_clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] data_tdata = '0;
    logic        data_tvalid = 1'b0;
    logic        data_tlast = 1'b0;
    logic        data_tready;
    logic [11:0] pixel_data;
    logic [9:0]  pixel_index;
    logic        pixel_valid;
    logic [31:0] line_timestamp;
    logic [31:0] line_period;
    logic        line_done;
    logic        line_error;
    logic [15:0] line_count;
    logic [15:0] error_count;
    logic [2:0]  dbg_state;

    sensor_packet_parser dut (
        .master_clock   (master_clock),
        .resetn         (resetn),
        .data_tdata     (data_tdata),
        .data_tvalid    (data_tvalid),
        .data_tlast     (data_tlast),
        .data_tready    (data_tready),
        .pixel_data     (pixel_data),
        .pixel_index    (pixel_index),
        .pixel_valid    (pixel_valid),
        .line_timestamp (line_timestamp),
        .line_period    (line_period),
        .line_done      (line_done),
        .line_error     (line_error),
        .line_count     (line_count),
        .error_count    (error_count),
        .dbg_state      (dbg_state)
    );

    always #5 master_clock = ~master_clock;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       stim[$];
    logic [21:0] exp_pix[$];
    logic [21:0] got_pix[$];
    int          got_done = 0, got_err = 0;
    int          exp_done = 0, exp_err = 0;

    // packet-level reference state
    logic [31:0] m_ts = 0, m_prev = 0, m_period = 0;
    bit          m_have_prev = 0;
    logic [15:0] m_lines = 0, m_errs = 0;

    int n_vec = 0, n_miss = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge master_clock) begin
        if (pixel_valid) got_pix.push_back({pixel_index, pixel_data});
        if (line_done) got_done++;
        if (line_error) got_err++;
        if (line_done || line_error) chk_eq("pulse_excl", 32'(line_done & line_error), 0);
    end

    function automatic logic [31:0] pack(input logic [11:0] a, input logic [11:0] b);
        return {4'h0, a, 4'h0, b};
    endfunction

    function automatic void m_error();
        exp_err++;
        if (m_errs != 16'hFFFF) m_errs++;
    endfunction

    function automatic void m_reset();
        m_ts = 0; m_prev = 0; m_period = 0; m_have_prev = 0; m_lines = 0; m_errs = 0;
    endfunction

    // header + timestamp + `nwords` data words; pixels are index or random
    function automatic void push_body(input logic [31:0] ts, input int nwords, input bit rnd,
                                      input int tlast_at);
        stim.push_back('{HDR, 1'b0});
        stim.push_back('{ts, 1'b0});
        m_ts = ts;
        for (int k = 0; k < nwords; k++) begin
            logic [11:0] a, b;
            a = rnd ? 12'($urandom) : 12'(2 * k);
            b = rnd ? 12'($urandom) : 12'(2 * k + 1);
            stim.push_back('{pack(a, b), k == tlast_at});
            exp_pix.push_back({10'(2 * k), a});
            exp_pix.push_back({10'(2 * k + 1), b});
        end
    endfunction

    function automatic void m_good_footer();
        stim.push_back('{FTR, 1'b1});
        exp_done++;
        m_lines++;
        m_period = m_have_prev ? m_ts - m_prev : 32'd0;
        m_prev = m_ts;
        m_have_prev = 1;
    endfunction

    function automatic void good_packet(input logic [31:0] ts, input bit rnd);
        push_body(ts, NWORDS, rnd, -1);
        m_good_footer();
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic l);
        int  tries = 0;
        bit  sent = 0;
        while (!sent) begin
            @(negedge master_clock);
            data_tdata  = d;
            data_tlast  = l;
            data_tvalid = ($urandom_range(0, 3) != 0);
            if (data_tvalid && data_tready) begin
                sent = 1;
                @(posedge master_clock);
            end else begin
                tries++;
                if (tries > 200) begin
                    chk_eq("drive_timeout", 32'(tries), 0);
                    sent = 1;
                end
            end
        end
    endtask

    task automatic run_stim();
        while (stim.size() > 0) begin
            beat_t b;
            b = stim.pop_front();
            drive_beat(b.d, b.l);
        end
        @(negedge master_clock);
        data_tvalid = 1'b0;
        repeat (4) @(negedge master_clock);
    endtask

    task automatic check_scenario(input string tag);
        int n;
        chk_eq({tag, "_npix"}, 32'(got_pix.size()), 32'(exp_pix.size()));
        n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
        for (int i = 0; i < n; i++) chk_eq({tag, "_pix"}, 32'(got_pix[i]), 32'(exp_pix[i]));
        chk_eq({tag, "_done"}, 32'(got_done), 32'(exp_done));
        chk_eq({tag, "_err"}, 32'(got_err), 32'(exp_err));
        chk_eq({tag, "_line_count"}, 32'(line_count), 32'(m_lines));
        chk_eq({tag, "_error_count"}, 32'(error_count), 32'(m_errs));
        chk_eq({tag, "_period"}, line_period, m_period);
        chk_eq({tag, "_tstamp"}, line_timestamp, m_ts);
        chk_eq({tag, "_state"}, 32'(dbg_state), 0);
        got_pix.delete(); exp_pix.delete();
        got_done = 0; got_err = 0; exp_done = 0; exp_err = 0;
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, "_tready"}, 32'(data_tready), 0);
        chk_eq({tag, "_pix"}, {8'h0, pixel_index, pixel_data, 1'b0, pixel_valid}, 0);
        chk_eq({tag, "_ts"}, line_timestamp, 0);
        chk_eq({tag, "_period"}, line_period, 0);
        chk_eq({tag, "_pulses"}, 32'({line_done, line_error}), 0);
        chk_eq({tag, "_counts"}, {line_count, error_count}, 0);
        chk_eq({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    initial begin
        repeat (3) @(negedge master_clock);
        check_zero("reset");
        resetn = 1'b1;
        @(negedge master_clock);

        // good packet with pixel == index, first line period 0
        good_packet(32'h0000_0100, 0);
        run_stim();
        check_scenario("good1");

        good_packet(32'h0000_1F40, 0);
        run_stim();
        check_scenario("good2");

        // early tlast on data word 10, then recovery
        push_body(32'h0000_2500, 11, 1, 10);
        m_error();
        run_stim();
        check_scenario("early_tlast");
        good_packet(32'h0000_3000 + 32'($urandom_range(0, 4095)), 1);
        run_stim();
        check_scenario("after_early");

        // bad footer without tlast, three junk beats, the last with tlast
        push_body($urandom, NWORDS, 1, -1);
        stim.push_back('{32'h1234_5678, 1'b0});
        m_error();
        for (int j = 0; j < 3; j++) stim.push_back('{$urandom, j == 2});
        run_stim();
        check_scenario("bad_footer");
        good_packet($urandom, 1);
        run_stim();
        check_scenario("after_footer");

        // leading garbage with random tlast, then a packet
        for (int j = 0; j < 5; j++) begin
            logic [31:0] w;
            w = $urandom;
            if (w == HDR) w = w ^ 32'h1;
            stim.push_back('{w, 1'($urandom)});
        end
        good_packet($urandom, 1);
        run_stim();
        check_scenario("garbage");

        // reset right after data word 19 is accepted: its odd pixel is lost
        push_body(32'hDEAD_0001, 20, 0, -1);
        void'(exp_pix.pop_back());
        while (stim.size() > 0) begin
            beat_t b;
            b = stim.pop_front();
            drive_beat(b.d, b.l);
        end
        @(negedge master_clock);
        data_tvalid = 1'b0;
        resetn = 1'b0;
        @(negedge master_clock);
        check_zero("mid_reset");
        @(negedge master_clock);
        resetn = 1'b1;
        m_reset();
        good_packet($urandom, 1);
        run_stim();
        check_scenario("after_reset");

        // padded word F000_0000 as data word 3
        stim.push_back('{HDR, 1'b0});
        stim.push_back('{32'h0000_7777, 1'b0});
        m_ts = 32'h0000_7777;
        for (int k = 0; k < NWORDS; k++) begin
            logic [31:0] w;
            w = (k == 3) ? 32'hF000_0000 : pack(12'(2 * k), 12'(2 * k + 1));
            stim.push_back('{w, 1'b0});
`ifdef PARSER_PAD_CHECK_EN
            if (k < 3) begin
                exp_pix.push_back({10'(2 * k), 12'(2 * k)});
                exp_pix.push_back({10'(2 * k + 1), 12'(2 * k + 1)});
            end
`else
            exp_pix.push_back({10'(2 * k), (k == 3) ? 12'h0 : 12'(2 * k)});
            exp_pix.push_back({10'(2 * k + 1), (k == 3) ? 12'h0 : 12'(2 * k + 1)});
`endif
        end
`ifdef PARSER_PAD_CHECK_EN
        stim.push_back('{FTR, 1'b1});
        m_error();
`else
        m_good_footer();
`endif
        run_stim();
        check_scenario("pad_word");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
